// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for a stable lock,
// then releases downstream logic; retries a bounded number of times before FAULT.
`timescale 1ns/1ps

module pll_reset_sequencer #(
    parameter int RST_HOLD_CYCLES     = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       req_reinit,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count
);

    localparam int CNT_MAX_A = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES
                                                                      : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
    localparam int CW        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        HOLD      = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [3:0]    retry_reg, retry_next;
    logic [1:0]    sync_reg;
    logic          lock_s;

    logic pll_rst_next, sys_reset_n_next, ready_next, fault_next;

    // pll_locked comes from another clock domain; only lock_s is used below.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], pll_locked};
        end
    end

    assign lock_s = sync_reg[1];

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        retry_next = retry_reg;

        if (req_reinit) begin
            state_next = HOLD;
            cnt_next   = '0;
            retry_next = 4'd0;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_next = STABLE;
                        cnt_next   = '0;
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        cnt_next = '0;
                        if (retry_reg == RETRY_LIMIT) begin
                            state_next = FAULT;
                        end else begin
                            state_next = HOLD;
                            retry_next = retry_reg + 4'd1;
                        end
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        // A glitch restarts the lock wait but is not a failed attempt.
                        state_next = WAIT_LOCK;
                        cnt_next   = '0;
                    end else if (cnt_reg == STABLE_LAST) begin
                        state_next = RUN;
                        cnt_next   = '0;
                        retry_next = 4'd0;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_next = HOLD;
                        cnt_next   = '0;
                    end
                end
                FAULT: begin
                    state_next = FAULT;
                end
                default: begin
                    state_next = HOLD;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they update on the entry edge.
    always_comb begin
        pll_rst_next     = (state_next == HOLD) || (state_next == FAULT);
        sys_reset_n_next = (state_next == RUN);
        ready_next       = (state_next == RUN);
        fault_next       = (state_next == FAULT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= HOLD;
            cnt_reg     <= '0;
            retry_reg   <= 4'd0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            retry_reg   <= retry_next;
            pll_rst     <= pll_rst_next;
            sys_reset_n <= sys_reset_n_next;
            ready       <= ready_next;
            fault       <= fault_next;
        end
    end

    assign retry_count = retry_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small timing parameters
// (hold 4, timeout 32, stable 8, max retries 2).
`timescale 1ns/1ps

module tb_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       req_reinit = 1'b0;
    logic       pll_rst;
    logic       sys_reset_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_count;

    int total = 0;
    int bad   = 0;

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_TIMEOUT_CYCLES (32),
        .LOCK_STABLE_CYCLES  (8),
        .MAX_RETRIES         (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pll_locked  (pll_locked),
        .req_reinit  (req_reinit),
        .pll_rst     (pll_rst),
        .sys_reset_n (sys_reset_n),
        .ready       (ready),
        .fault       (fault),
        .retry_count (retry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: value=%0d (t=%0t)", tag, got, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_rst, input logic e_srn,
                              input logic e_rdy, input logic e_flt, input logic [3:0] e_rc);
        check({tag, ".pll_rst"},     32'(pll_rst),     32'(e_rst));
        check({tag, ".sys_reset_n"}, 32'(sys_reset_n), 32'(e_srn));
        check({tag, ".ready"},       32'(ready),       32'(e_rdy));
        check({tag, ".fault"},       32'(fault),       32'(e_flt));
        check({tag, ".retry_count"}, 32'(retry_count), 32'(e_rc));
    endtask

    // Advance n clock cycles; returns on a falling edge, away from the active edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic apply_reset(input logic lock_val);
        reset_n    = 1'b0;
        req_reinit = 1'b0;
        pll_locked = lock_val;
        step(2);
        check_outs("reset", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Clean lock: sync overlaps HOLD, so RUN is 4 + 1 + 8 = 13 edges after release.
        apply_reset(1'b1);
        step(3);
        check("clean.hold_end.pll_rst", 32'(pll_rst), 32'd1);
        step(1);
        check_outs("clean.wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(8);
        check("clean.pre_run.ready", 32'(ready), 32'd0);
        step(1);
        check_outs("clean.run", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // Lock loss in RUN: two sync edges, then HOLD on the third edge.
        pll_locked = 1'b0;
        step(2);
        check("loss.sync_delay.ready", 32'(ready), 32'd1);
        step(1);
        check_outs("loss.hold", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        pll_locked = 1'b1;
        step(3);
        check("loss.hold_end.pll_rst", 32'(pll_rst), 32'd1);
        step(1);
        check("loss.wait.pll_rst", 32'(pll_rst), 32'd0);
        step(8);
        check("loss.pre_run.ready", 32'(ready), 32'd0);
        step(1);
        check_outs("loss.relock_run", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // Asynchronous reset while in RUN, checked before the next clock edge.
        #2 reset_n = 1'b0;
        #1 check_outs("async_rst_in_run", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

        // Glitch in STABLE: one-cycle drop seen by the FSM at edge 11, RUN at edge 20.
        apply_reset(1'b1);
        step(8);
        check("glitch.stable.ready", 32'(ready), 32'd0);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        check_outs("glitch.back_to_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(2);
        check("glitch.no_early_run.ready", 32'(ready), 32'd0);
        step(6);
        check("glitch.pre_run.ready", 32'(ready), 32'd0);
        step(1);
        check_outs("glitch.run", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0);

        // No lock: each attempt is 4 + 32 = 36 cycles; third failure enters FAULT.
        apply_reset(1'b0);
        step(35);
        check_outs("nolock.a1_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        check_outs("nolock.a2_hold", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        step(35);
        check_outs("nolock.a2_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
        step(1);
        check_outs("nolock.a3_hold", 1'b1, 1'b0, 1'b0, 1'b0, 4'd2);
        step(35);
        check_outs("nolock.a3_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd2);
        step(1);
        check_outs("nolock.fault", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        step(50);
        check_outs("nolock.fault_held", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
        pll_locked = 1'b1;
        step(10);
        check_outs("fault.ignores_lock", 1'b1, 1'b0, 1'b0, 1'b1, 4'd2);

        // req_reinit in FAULT.
        req_reinit = 1'b1;
        step(1);
        req_reinit = 1'b0;
        pll_locked = 1'b0;
        check_outs("reinit.from_fault", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(35);
        check_outs("reinit.a1_wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        step(1);
        check_outs("reinit.a2_hold", 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
        step(35);
        check("reinit.a2_wait.retry_count", 32'(retry_count), 32'd1);

        // req_reinit on the same cycle as a timeout: no increment, back to HOLD.
        req_reinit = 1'b1;
        step(1);
        req_reinit = 1'b0;
        check_outs("reinit.on_timeout", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        step(3);
        check("reinit.full_hold.pll_rst", 32'(pll_rst), 32'd1);
        step(1);
        check_outs("reinit.wait", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
